// File: rtl/alu_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | alu_pkg : opcode encoding and default operand width for alu_4bit     |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package alu_pkg;

  localparam int ALU_WIDTH = 4;

  typedef enum logic [2:0] {
    OP_ADD = 3'd0,
    OP_SUB = 3'd1,
    OP_AND = 3'd2,
    OP_OR  = 3'd3,
    OP_XOR = 3'd4,
    OP_NOT = 3'd5,
    OP_SHL = 3'd6,
    OP_SHR = 3'd7
  } alu_op_e;

endpackage : alu_pkg
`default_nettype wire

// File: rtl/alu_4bit_comb.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | alu_4bit_comb : combinational function unit, WIDTH+1-bit result      |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module alu_4bit_comb
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       sel,
  output logic [WIDTH:0]   result
);

  logic [WIDTH:0] a_ext;
  logic [WIDTH:0] b_ext;

  assign a_ext = {1'b0, a};
  assign b_ext = {1'b0, b};

  // Zero-extended subtraction leaves the borrow in the top bit.
  always_comb begin
    result = '0;
    case (alu_op_e'(sel))
      OP_ADD:  result = a_ext + b_ext;
      OP_SUB:  result = a_ext - b_ext;
      OP_AND:  result = a_ext & b_ext;
      OP_OR:   result = a_ext | b_ext;
      OP_XOR:  result = a_ext ^ b_ext;
      OP_NOT:  result = {1'b0, ~a};
      OP_SHL:  result = {a, 1'b0};
      OP_SHR:  result = {2'b00, a[WIDTH-1:1]};
      default: result = '0;
    endcase
  end

endmodule : alu_4bit_comb
`default_nettype wire

// File: rtl/alu_4bit.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | alu_4bit : registered 8-op ALU with valid pipeline and zero flag     |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module alu_4bit
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       sel,
  output logic [WIDTH:0]   out,
  output logic             out_valid,
  output logic             zero
);

  logic [WIDTH:0] result;
  logic [WIDTH:0] out_d,       out_q;
  logic           out_valid_d, out_valid_q;
  logic           zero_d,      zero_q;

  alu_4bit_comb #(
    .WIDTH (WIDTH)
  ) u_comb (
    .a      (a),
    .b      (b),
    .sel    (sel),
    .result (result)
  );

  // Idle cycles hold the last result but drop both qualifiers.
  always_comb begin
    out_d       = out_q;
    out_valid_d = 1'b0;
    zero_d      = 1'b0;
    if (in_valid) begin
      out_d       = result;
      out_valid_d = 1'b1;
      zero_d      = (result == '0);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_q       <= '0;
      out_valid_q <= 1'b0;
      zero_q      <= 1'b0;
    end else begin
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
      zero_q      <= zero_d;
    end
  end

  assign out       = out_q;
  assign out_valid = out_valid_q;
  assign zero      = zero_q;

endmodule : alu_4bit
`default_nettype wire

// File: tb/tb_alu_4bit.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_alu_4bit : directed-vector self-checking bench for alu_4bit       |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_alu_4bit;

  localparam int WIDTH = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             in_valid = 1'b0;
  logic [WIDTH-1:0] a = '0;
  logic [WIDTH-1:0] b = '0;
  logic [2:0]       sel = '0;
  logic [WIDTH:0]   out;
  logic             out_valid;
  logic             zero;

  int total = 0;
  int bad   = 0;

  alu_4bit #(
    .WIDTH (WIDTH)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .a         (a),
    .b         (b),
    .sel       (sel),
    .out       (out),
    .out_valid (out_valid),
    .zero      (zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Drive one cycle of inputs, then sample just after the capturing edge.
  task automatic step(input logic r, input logic v, input logic [3:0] ta,
                      input logic [3:0] tb, input logic [2:0] ts);
    rst = r; in_valid = v; a = ta; b = tb; sel = ts;
    @(posedge clk);
    #1;
  endtask

  task automatic expect_out(input string tag, input logic [4:0] e_out,
                            input logic e_valid, input logic e_zero);
    chk({tag, ".out"},   32'(out),       32'(e_out));
    chk({tag, ".valid"}, 32'(out_valid), 32'(e_valid));
    chk({tag, ".zero"},  32'(zero),      32'(e_zero));
  endtask

  typedef struct {
    logic [2:0] sel;
    logic [4:0] exp;
  } sweep_t;

  sweep_t sweep [8] = '{
    '{3'b000, 5'b10010}, '{3'b001, 5'b00100}, '{3'b010, 5'b00011},
    '{3'b011, 5'b01111}, '{3'b100, 5'b01100}, '{3'b101, 5'b00100},
    '{3'b110, 5'b10110}, '{3'b111, 5'b00101}
  };

  initial begin
    // Reset held two cycles with a valid input present.
    step(1'b1, 1'b1, 4'b1011, 4'b0111, 3'b000);
    expect_out("rst0", 5'b00000, 1'b0, 1'b0);
    step(1'b1, 1'b1, 4'b1011, 4'b0111, 3'b000);
    expect_out("rst1", 5'b00000, 1'b0, 1'b0);

    for (int i = 0; i < 8; i++) begin
      step(1'b0, 1'b1, 4'b1011, 4'b0111, sweep[i].sel);
      expect_out($sformatf("sweep%0d", i), sweep[i].exp, 1'b1, 1'b0);
    end

    step(1'b0, 1'b1, 4'b0011, 4'b0101, 3'b001);
    expect_out("sub_borrow", 5'b11110, 1'b1, 1'b0);
    step(1'b0, 1'b1, 4'b0110, 4'b0110, 3'b001);
    expect_out("sub_equal", 5'b00000, 1'b1, 1'b1);
    step(1'b0, 1'b1, 4'b0000, 4'b1111, 3'b001);
    expect_out("sub_0_15", 5'b10001, 1'b1, 1'b0);
    step(1'b0, 1'b1, 4'b1111, 4'b1111, 3'b000);
    expect_out("add_max", 5'b11110, 1'b1, 1'b0);
    step(1'b0, 1'b1, 4'b1111, 4'b0000, 3'b010);
    expect_out("and_zero", 5'b00000, 1'b1, 1'b1);
    step(1'b0, 1'b1, 4'b0000, 4'b1010, 3'b101);
    expect_out("not_zero", 5'b01111, 1'b1, 1'b0);
    step(1'b0, 1'b1, 4'b1001, 4'b0110, 3'b110);
    expect_out("shl_msb", 5'b10010, 1'b1, 1'b0);

    // Valid gating: idle cycle holds out and drops valid/zero.
    step(1'b0, 1'b1, 4'b0101, 4'b0101, 3'b100);
    expect_out("gate_a", 5'b00000, 1'b1, 1'b1);
    step(1'b0, 1'b0, 4'b1111, 4'b0001, 3'b000);
    expect_out("gate_idle", 5'b00000, 1'b0, 1'b0);
    step(1'b0, 1'b1, 4'b0010, 4'b0011, 3'b000);
    expect_out("gate_b", 5'b00101, 1'b1, 1'b0);
    step(1'b0, 1'b0, 4'b1111, 4'b1111, 3'b000);
    expect_out("gate_hold", 5'b00101, 1'b0, 1'b0);

    // Mid-stream reset drops the pending input.
    step(1'b0, 1'b1, 4'b1011, 4'b0111, 3'b000);
    expect_out("mid_add", 5'b10010, 1'b1, 1'b0);
    step(1'b1, 1'b1, 4'b1011, 4'b0111, 3'b000);
    expect_out("mid_rst", 5'b00000, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b0, 4'b1011, 4'b0111, 3'b000);
      expect_out($sformatf("post_rst%0d", i), 5'b00000, 1'b0, 1'b0);
    end
    step(1'b0, 1'b1, 4'b1000, 4'b0001, 3'b111);
    expect_out("post_rst_op", 5'b00100, 1'b1, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_alu_4bit
`default_nettype wire

// File: doc/alu_4bit.md
Name: alu_4bit

Overview:
- Registered 4-bit, 8-operation ALU: two operands plus a 3-bit opcode in, 5-bit result out.
- Result bit 4 carries the carry, borrow or shifted-out bit.
- Used as a leaf datapath block: one clock, one-cycle latency, no backpressure.
- Inputs are sampled every cycle; a valid strobe qualifies them.

Parameters:
- WIDTH, 4, operand width; the result is WIDTH+1 bits. All test values below assume the default.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous reset, active-high
- in_valid  in  1  qualifies a, b and sel this cycle
- a  in  WIDTH  operand A
- b  in  WIDTH  operand B
- sel  in  3  opcode
- out  out  WIDTH+1  registered result
- out_valid  out  1  out holds a result computed from a valid input
- zero  out  1  registered; high when out equals 0 and out_valid is high

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- Reset: on a clk edge with rst=1, out=0, out_valid=0 and zero=0. rst has priority over in_valid.
- Latency: exactly 1 cycle.
  - At an edge with in_valid=1 and rst=0: out <= f(a,b,sel), out_valid <= 1, zero <= (f==0).
  - At an edge with in_valid=0: out keeps its previous value, out_valid <= 0, zero <= 0.
- No stall or handshake; a new operation can be accepted every cycle.
- Opcodes (a, b zero-extended to WIDTH+1 bits before the operation):
  - 000 ADD: a+b; out[4] is the carry.
  - 001 SUB: a-b as a 5-bit two's-complement result; out[4]=1 iff a<b unsigned (borrow).
  - 010 AND: {0, a&b}
  - 011 OR: {0, a|b}
  - 100 XOR: {0, a^b}
  - 101 NOT: {0, ~a}; b is ignored.
  - 110 SHL: {a, 1'b0}; out[4] is the old a[3]. b is ignored.
  - 111 SHR: {0, 0, a[3:1]}; a[0] is discarded. b is ignored.
- The datapath is purely combinational into the output register; it has no other internal state.
- No X propagation: sel is fully decoded.
- Boundary conditions:
  - ADD 15+15 = 11110.
  - SUB with a==b gives 0 and zero=1.
  - SUB 0-15 = 10001.
  - A mid-stream reset clears the output on that edge; the pending input is dropped.

Decomposition:
- Shared package alu_pkg holds:
  - an opcode enum: OP_ADD=0, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_NOT, OP_SHL, OP_SHR
  - the WIDTH default constant
- One natural sub-module, alu_4bit_comb: a combinational function unit taking (a, b, sel) and producing the WIDTH+1-bit result.
- The top level, alu_4bit, adds the output register, the valid pipeline and the zero flag.

Test Plan:
- Reset: hold rst=1 for 2 cycles with in_valid=1 -> out=00000, out_valid=0, zero=0 throughout.
- Opcode sweep: a=1011, b=0111, in_valid=1, sel 000..111 on consecutive cycles. out one cycle later must be:
  - 000: 10010
  - 001: 00100
  - 010: 00011
  - 011: 01111
  - 100: 01100
  - 101: 00100
  - 110: 10110
  - 111: 00101
- Borrow and zero:
  - SUB a=0011, b=0101 -> out=11110, zero=0.
  - SUB a=0110, b=0110 -> out=00000, zero=1.
- Carry and extremes:
  - ADD 1111+1111 -> 11110.
  - AND a=1111, b=0000 -> 00000, zero=1.
  - NOT a=0000 -> 01111.
- Valid gating: in_valid=0 for one cycle between two valid ops -> out_valid deasserts for that cycle and out holds the prior result.
- Reset mid-stream: rst=1 on the cycle after a valid ADD 1011+0111 -> the next edge gives out=00000 and out_valid=0, and the result 10010 never appears with out_valid=1 after reset.
